seg7_page_ctrl: RTL and testbench
=================================

Name: seg7_page_ctrl

Overview:
- Display-source scheduler in front of seg7_module.
- Shares the 4-byte 7-segment display (b3..b0) among N_SRC 32-bit status sources, such as accelerator state, layer counter, cycle count and checksum.
- Page selection comes from a debounced push-button or an auto-rotate timer.
- Holds a registered snapshot per page, refreshed on source update strobes, with freeze and update-flash support.

Parameters:
- N_SRC, 4: number of 32-bit sources/pages, 2..16.
- DB_CYCLES, 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- ROT_CYCLES, 200000000: auto-rotate period in cycles.
- FLASH_CYCLES, 25000000: upd_flash high time after a refresh of the shown page.
- PW, $clog2(N_SRC): page index width (derived, not overridable).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- src_data  in  32*N_SRC  packed sources; source i at [32i+31:32i]
- src_upd  in  N_SRC  per-source one-cycle strobe: new value on src_data
- btn_next  in  1  raw asynchronous push-button, high = pressed
- auto_en  in  1  level; 1 = auto-rotate pages
- freeze  in  1  level; 1 = hold page and displayed value
- b3_data  out  8  disp[31:24] to seg7_module
- b2_data  out  8  disp[23:16]
- b1_data  out  8  disp[15:8]
- b0_data  out  8  disp[7:0]
- page_idx  out  PW  current page
- page_led  out  N_SRC  one-hot of page_idx
- upd_flash  out  1  high for FLASH_CYCLES after the shown page refreshes

Behaviour:
- Reset (async, active-high) sets:
  - disp, and therefore all b*_data, to 0; page_idx to 0; page_led to 1; upd_flash to 0.
  - All counters to 0; debounce FSM to IDLE; init_pend to 1.
- Button path:
  - 2-FF synchronizer, then debounce FSM with states IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
  - IDLE: sync=1 goes to WAIT_PRESS with cnt=1.
  - WAIT_PRESS: sync=0 returns to IDLE. Otherwise cnt increments; at cnt==DB_CYCLES go to PRESSED and emit a one-cycle next_req.
  - PRESSED: sync=0 goes to WAIT_RELEASE with cnt=1.
  - WAIT_RELEASE: sync=1 returns to PRESSED. Otherwise cnt increments; at cnt==DB_CYCLES go to IDLE.
  - Holding the button produces exactly one next_req. A glitch shorter than DB_CYCLES produces none.
- Rotate timer:
  - Counts only while auto_en=1 and freeze=0.
  - At ROT_CYCLES-1 emits rot_tick and wraps to 0.
  - Cleared when auto_en=0 or on any accepted advance; manual presses restart the period.
  - Held, not cleared, while freeze=1.
- Advance:
  - adv = (next_req | rot_tick) & ~freeze. Coincident next_req and rot_tick yield a single advance.
  - Requests during freeze are dropped, not queued.
  - New page = page_idx+1, wrapping N_SRC-1 to 0.
  - page_idx, page_led and disp <= src_data[new page] all update on the same edge.
  - Latency: visible one cycle after the next_req/rot_tick cycle.
- Refresh: freeze=0, no adv, and src_upd[page_idx]=1 gives disp <= src_data[page_idx] at the next edge, and upd_flash restarts.
  - src_upd of non-shown pages is ignored.
- Simultaneous events:
  - adv with src_upd on the old page: adv wins, new page loaded, no flash.
  - adv with src_upd on the new page: new page loaded and flash starts.
- Init load:
  - First edge after reset release with freeze=0 loads src_data[0] and clears init_pend.
  - If freeze=1, init_pend stays set until freeze falls.
- upd_flash: counter loaded with FLASH_CYCLES on refresh. Output is high while the counter is non-zero. An advance clears it unless the flash was started by the same adv/src_upd event.
- Freeze:
  - Blocks advance, refresh and init load.
  - The debounce FSM keeps running.
  - The flash counter continues counting down.
- Reset asserted mid-operation forces all reset values immediately, including mid-debounce and mid-flash.

Decomposition:
- Package seg7_ctrl_pkg:
  - Debounce state enum (IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE).
  - Byte-lane index constants B3..B0.
  - Function for page wrap increment.
- One sub-module btn_debounce:
  - Contains the synchronizer and debounce FSM.
  - Parameter DB_CYCLES.
  - Ports clock, reset, btn_raw, pulse.
- Timer, page register and snapshot logic stay in the top.

Test Plan:
Bench uses N_SRC=4, DB_CYCLES=4, ROT_CYCLES=10, FLASH_CYCLES=3; src i = 32'hA0B0C0D0+i.
1. Reset release, freeze=0 -> next edge b3..b0 = A0,B0,C0,D0, page_idx=0, page_led=0001, upd_flash=0.
2. btn_next high 3 cycles after sync, then low -> no page change. btn_next held 20 cycles -> exactly one advance to page 1, b0_data=D1, page_led=0010.
3. auto_en=1 for 45 cycles -> page sequence 1,2,3,0 at 10-cycle spacing. Wrap 3->0 shows A0B0C0D0.
4. Shown page 2; set src2=32'h12345678 with src_upd[2] pulse -> next edge b3..b0 = 12,34,56,78 and upd_flash high 3 cycles. src_upd[1] pulse -> no change.
5. freeze=1; press button and let rot_tick occur; pulse src_upd on the shown page -> page and disp unchanged. freeze=0 -> timer resumes from its held count.
6. next_req and rot_tick coincident -> single advance. Assert reset mid-debounce (WAIT_PRESS) -> outputs zero immediately; after release no spurious advance.

Source files
------------

// File: rtl/seg7_ctrl_pkg.sv
// Shared types and helpers for the seg7 page controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package seg7_ctrl_pkg;

  // Push-button debounce states: stable-low, qualifying a press, stable-high, qualifying a release
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } db_state_t;

  // Byte-lane positions of the 32-bit display word; B3 is the leftmost digit pair
  localparam int B3 = 3;
  localparam int B2 = 2;
  localparam int B1 = 1;
  localparam int B0 = 0;

  // Next page index, wrapping the last page back to page 0
  function automatic int page_wrap_inc(input int page, input int n_pages);
    return (page >= n_pages - 1) ? 0 : page + 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debouncer; emits one pulse per accepted press.
// Latency: 2 sync cycles + DB_CYCLES stable cycles, pulse registered (one cycle after acceptance).
// Backpressure: none; glitches shorter than DB_CYCLES are discarded.
module btn_debounce
  import seg7_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync_q1;
  logic          sync_q2;
  db_state_t     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          at_limit;

  // cnt holds the number of consecutive cycles the new level has been seen
  assign cnt_inc  = cnt + CW'(1);
  assign at_limit = (cnt_inc == CW'(DB_CYCLES));

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce FSM: a level change is accepted only after DB_CYCLES identical samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_q2) begin
            state <= WAIT_PRESS;
            cnt   <= CW'(1);
          end
        end
        WAIT_PRESS: begin
          if (!sync_q2) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
            if (at_limit) begin
              state <= PRESSED;
              pulse <= 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!sync_q2) begin
            state <= WAIT_RELEASE;
            cnt   <= CW'(1);
          end
        end
        WAIT_RELEASE: begin
          if (sync_q2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
            if (at_limit) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seg7_page_ctrl.sv
// Display-source scheduler: pages N_SRC 32-bit status words onto the 4-byte seg7 display.
// Latency: page change / refresh visible one edge after next_req, rot_tick or src_upd.
// Backpressure: none; requests arriving while frozen are dropped, never queued.
module seg7_page_ctrl
  import seg7_ctrl_pkg::*;
#(
  parameter int  N_SRC        = 4,
  parameter int  DB_CYCLES    = 1000000,
  parameter int  ROT_CYCLES   = 200000000,
  parameter int  FLASH_CYCLES = 25000000,
  localparam int PW           = $clog2(N_SRC)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [32*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_upd,
  input  logic               btn_next,
  input  logic               auto_en,
  input  logic               freeze,
  output logic [7:0]         b3_data,
  output logic [7:0]         b2_data,
  output logic [7:0]         b1_data,
  output logic [7:0]         b0_data,
  output logic [PW-1:0]      page_idx,
  output logic [N_SRC-1:0]   page_led,
  output logic               upd_flash
);

  localparam int RW = (ROT_CYCLES > 1) ? $clog2(ROT_CYCLES) : 1;
  localparam int FW = $clog2(FLASH_CYCLES + 1);

  logic          next_req;
  logic          rot_tick;
  logic          adv;
  logic          refresh;
  logic          init_load;
  logic          flash_start;
  logic          init_pend;
  logic [PW-1:0] page_nxt;
  logic [31:0]   word_cur;
  logic [31:0]   word_nxt;
  logic [31:0]   disp;
  logic [RW-1:0] rot_cnt;
  logic [FW-1:0] flash_cnt;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .clock  (clock),
    .reset  (reset),
    .btn_raw(btn_next),
    .pulse  (next_req)
  );

  assign page_nxt = PW'(page_wrap_inc(int'(page_idx), N_SRC));
  assign word_cur = src_data[{page_idx, 5'd0} +: 32];
  assign word_nxt = src_data[{page_nxt, 5'd0} +: 32];

  // Advance is suppressed until the first snapshot has been taken after reset
  assign rot_tick    = auto_en & ~freeze & (rot_cnt == RW'(ROT_CYCLES - 1));
  assign adv         = (next_req | rot_tick) & ~freeze & ~init_pend;
  assign refresh     = ~freeze & ~adv & src_upd[page_idx];
  assign init_load   = init_pend & ~freeze;
  // An update on the incoming page during an advance still counts as a fresh value
  assign flash_start = refresh | (adv & src_upd[page_nxt]);

  // Auto-rotate period counter; held while frozen, restarted by any accepted advance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rot_cnt <= '0;
    end else if (!auto_en) begin
      rot_cnt <= '0;
    end else if (!freeze) begin
      if (adv || rot_tick) begin
        rot_cnt <= '0;
      end else begin
        rot_cnt <= rot_cnt + RW'(1);
      end
    end
  end

  // Page register and display snapshot; advance beats init load beats refresh
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      page_idx  <= '0;
      disp      <= '0;
      init_pend <= 1'b1;
    end else begin
      if (adv) begin
        page_idx <= page_nxt;
        disp     <= word_nxt;
      end else if (init_load) begin
        disp <= src_data[31:0];
      end else if (refresh) begin
        disp <= word_cur;
      end
      if (init_load) begin
        init_pend <= 1'b0;
      end
    end
  end

  // Update-flash timer; keeps counting down through freeze, cleared when the page moves away
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flash_cnt <= '0;
    end else if (flash_start) begin
      flash_cnt <= FW'(FLASH_CYCLES);
    end else if (adv) begin
      flash_cnt <= '0;
    end else if (flash_cnt != '0) begin
      flash_cnt <= flash_cnt - FW'(1);
    end
  end

  assign upd_flash = (flash_cnt != '0);
  assign page_led  = N_SRC'(1) << page_idx;

  assign b3_data = disp[B3*8 +: 8];
  assign b2_data = disp[B2*8 +: 8];
  assign b1_data = disp[B1*8 +: 8];
  assign b0_data = disp[B0*8 +: 8];

endmodule

// File: tb/tb_seg7_page_ctrl.sv
// Bench for seg7_page_ctrl: reference model feeds an expected-output queue every edge,
// a negedge monitor pops and compares; directed checks cover the named scenarios.
// Runs a fixed number of cycles under a watchdog.
module tb_seg7_page_ctrl;

  localparam int N_SRC = 4;
  localparam int DB    = 4;
  localparam int ROT   = 10;
  localparam int FLASH = 3;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [32*N_SRC-1:0]  src_data;
  logic [N_SRC-1:0]     src_upd;
  logic                 btn_next;
  logic                 auto_en;
  logic                 freeze;
  logic [7:0]           b3_data, b2_data, b1_data, b0_data;
  logic [1:0]           page_idx;
  logic [N_SRC-1:0]     page_led;
  logic                 upd_flash;

  seg7_page_ctrl #(
    .N_SRC       (N_SRC),
    .DB_CYCLES   (DB),
    .ROT_CYCLES  (ROT),
    .FLASH_CYCLES(FLASH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .src_data (src_data),
    .src_upd  (src_upd),
    .btn_next (btn_next),
    .auto_en  (auto_en),
    .freeze   (freeze),
    .b3_data  (b3_data),
    .b2_data  (b2_data),
    .b1_data  (b1_data),
    .b0_data  (b0_data),
    .page_idx (page_idx),
    .page_led (page_led),
    .upd_flash(upd_flash)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] disp;
    logic [1:0]  page;
    logic        flash;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state (spec-level view: page number, shown word, timers, button level)
  int          m_page;
  logic [31:0] m_disp;
  int          m_flash;
  int          m_rot;
  bit          m_init;
  bit          m_lvl;
  int          m_run;
  bit          m_req;
  bit          m_d0, m_d1;

  function automatic logic [31:0] word_of(input logic [32*N_SRC-1:0] bus, input int i);
    return bus[32*i +: 32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one step per clock edge, pushes the outputs expected after that edge
  always @(posedge clock or posedge reset) begin
    bit   tick, adv, refresh, sync_now;
    int   np;
    exp_t e;
    if (reset) begin
      m_page = 0; m_disp = '0; m_flash = 0; m_rot = 0; m_init = 1'b1;
      m_lvl = 1'b0; m_run = 0; m_req = 1'b0; m_d0 = 1'b0; m_d1 = 1'b0;
      exp_q.delete();
    end else begin
      tick    = auto_en && !freeze && (m_rot == ROT - 1);
      adv     = (m_req || tick) && !freeze && !m_init;
      np      = (m_page + 1) % N_SRC;
      refresh = !freeze && !adv && src_upd[m_page];
      if (refresh || (adv && src_upd[np])) m_flash = FLASH;
      else if (adv)                        m_flash = 0;
      else if (m_flash > 0)                m_flash = m_flash - 1;
      if (adv)                     m_disp = word_of(src_data, np);
      else if (m_init && !freeze)  m_disp = word_of(src_data, 0);
      else if (refresh)            m_disp = word_of(src_data, m_page);
      if (!freeze) m_init = 1'b0;
      if (adv) m_page = np;
      if (!auto_en)     m_rot = 0;
      else if (!freeze) m_rot = (adv || tick) ? 0 : m_rot + 1;
      // button seen two edges late; a level is accepted after DB consecutive differing samples
      sync_now = m_d1;
      m_req    = 1'b0;
      if (sync_now != m_lvl) begin
        m_run++;
        if (m_run == DB) begin
          m_lvl = sync_now;
          m_run = 0;
          m_req = sync_now;
        end
      end else begin
        m_run = 0;
      end
      m_d1 = m_d0;
      m_d0 = btn_next;
      e.disp  = m_disp;
      e.page  = 2'(m_page);
      e.flash = (m_flash != 0);
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs on the falling edge against reset values or the model queue
  always @(negedge clock) begin
    if (reset) begin
      check("rst_disp",  {b3_data, b2_data, b1_data, b0_data}, 32'h0);
      check("rst_page",  32'(page_idx),  32'h0);
      check("rst_led",   32'(page_led),  32'h1);
      check("rst_flash", 32'(upd_flash), 32'h0);
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sb_disp",  {b3_data, b2_data, b1_data, b0_data}, mon_e.disp);
      check("sb_page",  32'(page_idx),  32'(mon_e.page));
      check("sb_led",   32'(page_led),  32'(4'b0001 << mon_e.page));
      check("sb_flash", 32'(upd_flash), 32'(mon_e.flash));
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press();
    btn_next = 1'b1;
    cycles(12);
    btn_next = 1'b0;
    cycles(10);
  endtask

  task automatic load_defaults();
    for (int i = 0; i < N_SRC; i++) src_data[32*i +: 32] = 32'hA0B0C0D0 + 32'(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int prev, changes, n, old_page, run_left;
    load_defaults();
    src_upd = '0; btn_next = 1'b0; auto_en = 1'b0; freeze = 1'b0;
    #1 reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(1);

    // 1: init load on first edge after reset
    check("t1_disp",  {b3_data, b2_data, b1_data, b0_data}, 32'hA0B0C0D0);
    check("t1_page",  32'(page_idx),  32'd0);
    check("t1_led",   32'(page_led),  32'b0001);
    check("t1_flash", 32'(upd_flash), 32'd0);

    // 2: short glitch ignored, long hold gives exactly one advance
    btn_next = 1'b1; cycles(3); btn_next = 1'b0; cycles(10);
    check("t2_glitch_page", 32'(page_idx), 32'd0);
    btn_next = 1'b1; cycles(20); btn_next = 1'b0; cycles(10);
    check("t2_hold_page", 32'(page_idx), 32'd1);
    check("t2_hold_b0",   32'(b0_data),  32'hD1);
    check("t2_hold_led",  32'(page_led), 32'b0010);

    // 3: auto-rotate, four advances in 45 cycles
    auto_en = 1'b1;
    prev = int'(page_idx); changes = 0;
    for (int c = 0; c < 45; c++) begin
      cycles(1);
      if (int'(page_idx) != prev) begin
        changes++;
        prev = int'(page_idx);
      end
    end
    auto_en = 1'b0;
    check("t3_rot_count", 32'(changes), 32'd4);
    cycles(2);

    // 4: refresh of the shown page and flash; other pages ignored
    for (int k = 0; k < 8 && m_page != 2; k++) press();
    check("t4_on_page2", 32'(page_idx), 32'd2);
    src_data[95:64] = 32'h12345678; src_upd[2] = 1'b1;
    cycles(1);
    src_upd = '0;
    check("t4_refresh_disp", {b3_data, b2_data, b1_data, b0_data}, 32'h12345678);
    check("t4_flash_on",     32'(upd_flash), 32'd1);
    cycles(2);
    check("t4_flash_last",   32'(upd_flash), 32'd1);
    cycles(1);
    check("t4_flash_off",    32'(upd_flash), 32'd0);
    src_data[63:32] = 32'hDEADBEEF; src_upd[1] = 1'b1;
    cycles(1);
    src_upd = '0;
    check("t4_other_upd", {b3_data, b2_data, b1_data, b0_data}, 32'h12345678);

    // 5: freeze holds page and value; timer resumes from its held count
    auto_en = 1'b1; cycles(5);
    freeze = 1'b1;
    btn_next = 1'b1; cycles(12); btn_next = 1'b0;
    src_data[95:64] = 32'h55AA55AA; src_upd[2] = 1'b1;
    cycles(1);
    src_upd = '0;
    cycles(8);
    check("t5_frz_page", 32'(page_idx), 32'd2);
    check("t5_frz_disp", {b3_data, b2_data, b1_data, b0_data}, 32'h12345678);
    freeze = 1'b0;
    n = 0;
    do begin
      cycles(1);
      n++;
    end while (page_idx == 2'd2 && n < 30);
    check("t5_resume_cycles", 32'(n), 32'd5);
    check("t5_resume_disp", {b3_data, b2_data, b1_data, b0_data}, 32'hA0B0C0D3);
    auto_en = 1'b0;
    cycles(2);

    // 6a: button pulse coincident with rot tick gives a single advance
    auto_en = 1'b1;
    n = 0;
    while (m_rot != 3 && n < 20) begin
      cycles(1);
      n++;
    end
    check("t6_align", 32'(m_rot), 32'd3);
    old_page = int'(page_idx);
    btn_next = 1'b1; cycles(12);
    check("t6_single_adv", 32'(page_idx), 32'((old_page + 1) % N_SRC));
    btn_next = 1'b0; auto_en = 1'b0;
    cycles(10);

    // random phase
    run_left = 1;
    for (int c = 0; c < 1500; c++) begin
      run_left--;
      if (run_left <= 0) begin
        btn_next = ~btn_next;
        run_left = $urandom_range(1, 10);
      end
      if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 39) == 0) freeze = ~freeze;
      src_upd = '0;
      for (int i = 0; i < N_SRC; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          src_data[32*i +: 32] = $urandom;
          src_upd[i] = 1'b1;
        end
      end
      cycles(1);
    end
    src_upd = '0; btn_next = 1'b0; auto_en = 1'b0; freeze = 1'b0;
    load_defaults();
    cycles(12);

    // 6b: reset mid-debounce, release while frozen, then no spurious advance
    btn_next = 1'b1; cycles(4);
    reset = 1'b1;
    #1;
    check("t6_rst_disp", {b3_data, b2_data, b1_data, b0_data}, 32'h0);
    check("t6_rst_page", 32'(page_idx), 32'd0);
    check("t6_rst_led",  32'(page_led), 32'b0001);
    btn_next = 1'b0;
    cycles(2);
    freeze = 1'b1;
    reset = 1'b0;
    cycles(3);
    check("t6_init_frozen", {b3_data, b2_data, b1_data, b0_data}, 32'h0);
    freeze = 1'b0;
    cycles(1);
    check("t6_init_load", {b3_data, b2_data, b1_data, b0_data}, 32'hA0B0C0D0);
    cycles(20);
    check("t6_no_spurious", 32'(page_idx), 32'd0);

    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
